hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Parametrised pipeline hazard controller for the in-order core: detects load-use dependencies between the ID and EX stages and taken branches resolved in EX, and drives PC / IF-ID enables plus IF-ID flush and ID-EX bubble controls. Generalises the single-cycle hazard logic with a configurable register-address width, multi-cycle load-use stalls, multi-cycle branch penalties, a stall/flush state machine with counters, and an x0 (zero register) exclusion. Sits beside the ID stage and feeds every pipeline-register enable and flush from IF through ID-EX.

## Interface
- REG_AW, 5, register-address width in bits.
- LOAD_LAT, 1, total stall cycles per load-use hazard; range 1..15.
- BR_PEN, 1, total flush cycles per taken branch; range 1..15.
- CNT_W, 16, width of the statistics counters.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  asynchronous, active-low reset.
- id_rs  input  REG_AW  source register 1 of the instruction in ID.
- id_rt  input  REG_AW  source register 2 of the instruction in ID.
- ex_rd  input  REG_AW  destination register of the instruction in EX.
- ex_memread  input  1  EX instruction is a load.
- ex_pcsrc  input  1  taken branch/jump resolved in EX this cycle.
- pc_en  output  1  PC write enable.
- ifid_en  output  1  IF-ID register write enable.
- ifid_flush  output  1  clear IF-ID to NOP on the next edge.
- idex_bubble  output  1  load NOP into ID-EX on the next edge.
- busy  output  1  FSM is in a state other than RUN.
- stall_cnt  output  CNT_W  stall cycles since reset.
- flush_cnt  output  CNT_W  flush cycles since reset.

## Operation
- Hazard detection, combinational: lu_hit = ex_memread & (ex_rd != 0) & ((ex_rd == id_rs) | (ex_rd == id_rt)). An ex_rd of zero never hits.
- FSM states: RUN, STALL, FLUSH. A 4-bit down-counter `rem` holds the remaining extra cycles.
- RUN: ex_pcsrc=1 -> flush this cycle; if BR_PEN>1, go to FLUSH with rem=BR_PEN-2. Otherwise lu_hit=1 -> stall this cycle; if LOAD_LAT>1, go to STALL with rem=LOAD_LAT-2. Otherwise stay in RUN.
- STALL: assert a stall. ex_pcsrc=1 aborts the stall: flush this cycle, then go to FLUSH (rem=BR_PEN-2) if BR_PEN>1, else to RUN. Otherwise go to RUN when rem=0; else decrement rem.
- FLUSH: assert a flush. Go to RUN when rem=0; else decrement rem. A new ex_pcsrc in FLUSH is ignored, because the EX-stage content is already a bubble.
- Stall outputs: pc_en=0, ifid_en=0, idex_bubble=1, ifid_flush=0.
- Flush outputs: pc_en=1, ifid_en=1, ifid_flush=1, idex_bubble=1.
- Idle outputs (RUN with no event): pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0.
- Priority: a taken branch beats a load-use stall in all states, because the instruction in ID is on the wrong path.
- busy=1 exactly when the state is STALL or FLUSH.

## Timing
- Detection-to-control latency is zero: outputs respond combinationally in the same cycle as lu_hit or ex_pcsrc.
- A load-use hazard holds PC and IF-ID for exactly LOAD_LAT consecutive cycles.
- A taken branch flushes for exactly BR_PEN consecutive cycles.
- Reset (rst=0) immediately forces state=RUN, rem=0, stall_cnt=0, flush_cnt=0, pc_en=1, ifid_en=1, ifid_flush=0, idex_bubble=0 and busy=0, regardless of the other inputs.
- Reset asserted in the middle of a stall or flush abandons it.
- Reset deassertion takes effect at the first rising edge after rst goes high.

## Configuration
- HAZARD_STATS_EN defined: stall_cnt increments on every clock edge at which a stall is being asserted; flush_cnt increments on every edge at which a flush is being asserted. Both saturate at 2^CNT_W-1.
- HAZARD_STATS_EN undefined: the counter logic is removed, the ports remain, and stall_cnt and flush_cnt are tied to 0.

## Test plan
- Load-use, LOAD_LAT=1: ex_memread=1, ex_rd=5, id_rs=5 for one cycle -> pc_en=0, ifid_en=0 and idex_bubble=1 for 1 cycle, then idle; busy stays 0.
- Load-use, LOAD_LAT=3: ex_rd=7 matches id_rt -> stall for exactly 3 cycles with busy=1 in cycles 2-3; with stats enabled, stall_cnt=3 afterwards.
- x0 exclusion: ex_memread=1, ex_rd=0, id_rs=0 -> no stall; outputs stay idle.
- Branch during stall, LOAD_LAT=3, BR_PEN=2: ex_pcsrc=1 in stall cycle 2 -> the same cycle shows ifid_flush=1 and pc_en=1, followed by 1 more flush cycle, then RUN; the stall is not resumed.
- Simultaneous events in RUN: lu_hit=1 and ex_pcsrc=1 -> flush outputs; stall_cnt unchanged.
- Asynchronous reset mid-FLUSH: drop rst between clock edges -> outputs go to their idle values immediately, and the counters read 0.

Source files
------------

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Load-use stall / taken-branch flush controller for the in-order
//            core. Optional statistics counters: define HAZARD_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl #(
   parameter int REG_AW   = 5,
   parameter int LOAD_LAT = 1,
   parameter int BR_PEN   = 1,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [REG_AW-1:0] id_rs,
   input  logic [REG_AW-1:0] id_rt,
   input  logic [REG_AW-1:0] ex_rd,
   input  logic              ex_memread,
   input  logic              ex_pcsrc,
   output logic              pc_en,
   output logic              ifid_en,
   output logic              ifid_flush,
   output logic              idex_bubble,
   output logic              busy,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   typedef enum logic [1:0] {
      S_RUN   = 2'd0,
      S_STALL = 2'd1,
      S_FLUSH = 2'd2
   } state_t;

   // rem counts the extra cycles after the one spent leaving RUN
   localparam int         C_LR        = (LOAD_LAT > 1) ? LOAD_LAT - 2 : 0;
   localparam int         C_BR        = (BR_PEN > 1) ? BR_PEN - 2 : 0;
   localparam logic [3:0] C_LOAD_REM  = C_LR[3:0];
   localparam logic [3:0] C_BR_REM    = C_BR[3:0];
   localparam bit         C_LOAD_MULT = (LOAD_LAT > 1);
   localparam bit         C_BR_MULT   = (BR_PEN > 1);

   state_t     r_state;
   state_t     w_state_nxt;
   logic [3:0] r_rem;
   logic [3:0] w_rem_nxt;
   logic       w_lu_hit;
   logic       w_stall_raw;
   logic       w_flush_raw;
   logic       w_stall;
   logic       w_flush;

   assign w_lu_hit = ex_memread && (ex_rd != '0) &&
                     ((ex_rd == id_rs) || (ex_rd == id_rt));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= S_RUN;
         r_rem   <= 4'd0;
      end else begin
         r_state <= w_state_nxt;
         r_rem   <= w_rem_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rem_nxt   = r_rem;
      w_stall_raw = 1'b0;
      w_flush_raw = 1'b0;
      case (r_state)
         S_RUN: begin
            if (ex_pcsrc) begin
               w_flush_raw = 1'b1;
               if (C_BR_MULT) begin
                  w_state_nxt = S_FLUSH;
                  w_rem_nxt   = C_BR_REM;
               end
            end else if (w_lu_hit) begin
               w_stall_raw = 1'b1;
               if (C_LOAD_MULT) begin
                  w_state_nxt = S_STALL;
                  w_rem_nxt   = C_LOAD_REM;
               end
            end
         end
         S_STALL: begin
            // the ID instruction is on the wrong path, so the branch wins
            if (ex_pcsrc) begin
               w_flush_raw = 1'b1;
               if (C_BR_MULT) begin
                  w_state_nxt = S_FLUSH;
                  w_rem_nxt   = C_BR_REM;
               end else begin
                  w_state_nxt = S_RUN;
                  w_rem_nxt   = 4'd0;
               end
            end else begin
               w_stall_raw = 1'b1;
               if (r_rem == 4'd0) w_state_nxt = S_RUN;
               else               w_rem_nxt   = r_rem - 4'd1;
            end
         end
         S_FLUSH: begin
            w_flush_raw = 1'b1;
            if (r_rem == 4'd0) w_state_nxt = S_RUN;
            else               w_rem_nxt   = r_rem - 4'd1;
         end
         default: begin
            w_state_nxt = S_RUN;
            w_rem_nxt   = 4'd0;
         end
      endcase
   end

   // reset must force idle controls even while the inputs still show events
   assign w_stall     = w_stall_raw && rst;
   assign w_flush     = w_flush_raw && rst;

   assign pc_en       = !w_stall;
   assign ifid_en     = !w_stall;
   assign ifid_flush  = w_flush;
   assign idex_bubble = w_stall || w_flush;
   assign busy        = (r_state != S_RUN);

`ifdef HAZARD_STATS_EN
   logic [CNT_W-1:0] r_stall_cnt;
   logic [CNT_W-1:0] r_flush_cnt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_stall_cnt <= '0;
         r_flush_cnt <= '0;
      end else begin
         if (w_stall && !(&r_stall_cnt)) r_stall_cnt <= r_stall_cnt + 1'b1;
         if (w_flush && !(&r_flush_cnt)) r_flush_cnt <= r_flush_cnt + 1'b1;
      end
   end

   assign stall_cnt = r_stall_cnt;
   assign flush_cnt = r_flush_cnt;
`else
   assign stall_cnt = '0;
   assign flush_cnt = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_ctrl
// Brief    : Scoreboard bench for hazard_ctrl (LOAD_LAT=3, BR_PEN=2, CNT_W=4).
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_ctrl;

   localparam int REG_AW   = 5;
   localparam int LOAD_LAT = 3;
   localparam int BR_PEN   = 2;
   localparam int CNT_W    = 4;
   localparam int CNT_MAX  = (1 << CNT_W) - 1;

   logic              clk = 1'b0;
   logic              rst = 1'b0;
   logic [REG_AW-1:0] id_rs = '0;
   logic [REG_AW-1:0] id_rt = '0;
   logic [REG_AW-1:0] ex_rd = '0;
   logic              ex_memread = 1'b0;
   logic              ex_pcsrc = 1'b0;
   logic              pc_en, ifid_en, ifid_flush, idex_bubble, busy;
   logic [CNT_W-1:0]  stall_cnt, flush_cnt;

   hazard_ctrl #(
      .REG_AW(REG_AW), .LOAD_LAT(LOAD_LAT), .BR_PEN(BR_PEN), .CNT_W(CNT_W)
   ) dut (
      .clk(clk), .rst(rst),
      .id_rs(id_rs), .id_rt(id_rt), .ex_rd(ex_rd),
      .ex_memread(ex_memread), .ex_pcsrc(ex_pcsrc),
      .pc_en(pc_en), .ifid_en(ifid_en), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .busy(busy),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             pc_en;
      logic             ifid_en;
      logic             ifid_flush;
      logic             idex_bubble;
      logic             busy;
      logic [CNT_W-1:0] scnt;
      logic [CNT_W-1:0] fcnt;
   } exp_t;

   exp_t q[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   // reference model: cycles of penalty still owed, and event totals
   int m_stall_left = 0;
   int m_flush_left = 0;
   int m_scnt = 0;
   int m_fcnt = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
   endtask

   task automatic step(input logic [REG_AW-1:0] rs, input logic [REG_AW-1:0] rt,
                       input logic [REG_AW-1:0] rd, input logic mr, input logic pc,
                       input logic rv);
      exp_t e;
      bit   lu, is_stall, is_flush;
      @(posedge clk);
      #1;
      id_rs = rs; id_rt = rt; ex_rd = rd;
      ex_memread = mr; ex_pcsrc = pc; rst = rv;
      lu = mr && (rd != 0) && (rd == rs || rd == rt);
      is_stall = 1'b0;
      is_flush = 1'b0;
      if (!rv) begin
         m_stall_left = 0; m_flush_left = 0; m_scnt = 0; m_fcnt = 0;
         e.busy = 1'b0;
      end else begin
         e.busy = (m_stall_left > 0) || (m_flush_left > 0);
         if (m_flush_left > 0) begin
            is_flush = 1'b1;
            m_flush_left--;
         end else if (pc) begin
            is_flush = 1'b1;
            m_flush_left = BR_PEN - 1;
            m_stall_left = 0;
         end else if (m_stall_left > 0) begin
            is_stall = 1'b1;
            m_stall_left--;
         end else if (lu) begin
            is_stall = 1'b1;
            m_stall_left = LOAD_LAT - 1;
         end
      end
      e.pc_en       = !is_stall;
      e.ifid_en     = !is_stall;
      e.ifid_flush  = is_flush;
      e.idex_bubble = is_stall || is_flush;
`ifdef HAZARD_STATS_EN
      e.scnt = CNT_W'(m_scnt);
      e.fcnt = CNT_W'(m_fcnt);
`else
      e.scnt = '0;
      e.fcnt = '0;
`endif
      if (is_stall && m_scnt < CNT_MAX) m_scnt++;
      if (is_flush && m_fcnt < CNT_MAX) m_fcnt++;
      q.push_back(e);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
   endtask

   // monitor: outputs are combinational, so every cycle presents a result
   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         chk("pc_en",       32'(pc_en),       32'(e.pc_en));
         chk("ifid_en",     32'(ifid_en),     32'(e.ifid_en));
         chk("ifid_flush",  32'(ifid_flush),  32'(e.ifid_flush));
         chk("idex_bubble", 32'(idex_bubble), 32'(e.idex_bubble));
         chk("busy",        32'(busy),        32'(e.busy));
         chk("stall_cnt",   32'(stall_cnt),   32'(e.scnt));
         chk("flush_cnt",   32'(flush_cnt),   32'(e.fcnt));
      end
   end

   initial begin
      // reset with a pending branch on the inputs: controls must stay idle
      step(5'd1, 5'd2, 5'd1, 1'b1, 1'b1, 1'b0);
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0);
      idle(2);
      // load-use on id_rt, 3-cycle stall
      step(5'd3, 5'd7, 5'd7, 1'b1, 1'b0, 1'b1);
      idle(4);
      // x0 never hits
      step(5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b1);
      step(5'd0, 5'd9, 5'd0, 1'b1, 1'b0, 1'b1);
      idle(1);
      // branch in stall cycle 2 aborts the stall
      step(5'd5, 5'd1, 5'd5, 1'b1, 1'b0, 1'b1);
      step(5'd5, 5'd1, 5'd5, 1'b1, 1'b1, 1'b1);
      idle(3);
      // simultaneous load-use and branch in RUN: branch wins
      step(5'd6, 5'd6, 5'd6, 1'b1, 1'b1, 1'b1);
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      idle(2);
      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         step(REG_AW'($urandom_range(0, 3)), REG_AW'($urandom_range(0, 3)),
              REG_AW'($urandom_range(0, 3)), ($urandom_range(0, 2) == 0),
              ($urandom_range(0, 7) == 0), 1'b1);
      end
      // reset dropped while in FLUSH
      idle(3);
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1);
      step(5'd2, 5'd2, 5'd2, 1'b1, 1'b1, 1'b0);
      step(5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b1);
      step(5'd4, 5'd0, 5'd4, 1'b1, 1'b0, 1'b1);
      idle(4);
      repeat (3) @(posedge clk);
      chk("queue_drained", 32'(q.size()), 32'd0);
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: bench did not finish, %0d checks done", n_chk);
      $fatal(1, "timeout");
   end

endmodule
`default_nettype wire
